// File: rtl/twos_to_sign_mag_norm.sv
// twos_to_sign_mag_norm
//   Converts the two's-complement mantissa sum from the FP add/sub datapath
//   into sign/magnitude form. The magnitude is then normalised so that the
//   hidden bit sits at MW-2, shifting one bit per cycle and adjusting the
//   exponent as it goes. IEEE-754 single fields go to the pack stage over a
//   valid/ready handshake. Rounding is by truncation.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   valid_in          sum_in/exp_in valid (only honoured while ready_out=1)
//   ready_out         block is idle and can accept an operand
//   sum_in [MW-1:0]   two's-complement mantissa sum
//   exp_in [EW-1:0]   biased exponent aligned to sum_in bit MW-2
//   valid_out         result fields valid, held until ready_in
//   ready_in          downstream accepts the result
//   sign_out          result sign
//   exp_out [EW-1:0]  result biased exponent
//   mant_out[MW-3:0]  result fraction, hidden bit dropped
//   zero_out          exact zero result
//   overflow          exponent saturated to all-ones (infinity)
//   underflow         result flushed to zero
module twos_to_sign_mag_norm #(
  parameter int MW = 25,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic [MW-1:0] sum_in,
  input  logic [EW-1:0] exp_in,
  output logic          valid_out,
  input  logic          ready_in,
  output logic          sign_out,
  output logic [EW-1:0] exp_out,
  output logic [MW-3:0] mant_out,
  output logic          zero_out,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic [1:0] {IDLE, CONV, NORM, DONE} state_t;

  localparam logic [EW-1:0] EXP_MAX = {EW{1'b1}};
  localparam logic [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [MW-1:0] MAG_ONE = MW'(1);

  // Magnitude of a two's-complement value as an MW-bit unsigned number.
  // The most negative input maps to 2^(MW-1), which still fits.
  function automatic logic [MW-1:0] abs_mag(input logic signed [MW-1:0] s);
    logic [MW-1:0] u;
    u = s;
    return u[MW-1] ? (~u + MAG_ONE) : u;
  endfunction

  state_t               state_q;
  logic signed [MW-1:0] sreg_q;
  logic [EW-1:0]        ereg_q;
  // In NORM the magnitude is always below 2^(MW-2), so only the bits below
  // the hidden position need storing; the hidden bit appears when bit MW-3
  // is about to be shifted into it.
  logic [MW-3:0]        mag_q;
  logic                 sign_q;

  logic                 ready_q, valid_q, sign_out_q, zero_q, ovf_q, unf_q;
  logic [EW-1:0]        exp_out_q;
  logic [MW-3:0]        mant_q;

  logic                 conv_sign_d;
  logic [MW-1:0]        conv_mag_d;
  logic [MW-3:0]        norm_mag_d;
  logic [EW-1:0]        exp_inc_d, exp_dec_d;

  always_comb begin
    conv_sign_d = sreg_q[MW-1];
    conv_mag_d  = abs_mag(sreg_q);
    norm_mag_d  = {mag_q[MW-4:0], 1'b0};
    exp_inc_d   = ereg_q + EXP_ONE;
    exp_dec_d   = ereg_q - EXP_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      sign_out_q <= 1'b0;
      exp_out_q  <= '0;
      mant_q     <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            sreg_q  <= $signed(sum_in);
            ereg_q  <= exp_in;
            ready_q <= 1'b0;
            state_q <= CONV;
          end
        end
        // Sign recovery and the single-cycle outcomes; only denormalised
        // magnitudes continue into NORM.
        CONV: begin
          sign_q <= conv_sign_d;
          mag_q  <= conv_mag_d[MW-3:0];
          zero_q <= 1'b0;
          ovf_q  <= 1'b0;
          unf_q  <= 1'b0;
          if (conv_mag_d == '0) begin
            sign_out_q <= 1'b0;
            exp_out_q  <= '0;
            mant_q     <= '0;
            zero_q     <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end else if (ereg_q == EXP_MAX) begin
            sign_out_q <= conv_sign_d;
            exp_out_q  <= EXP_MAX;
            mant_q     <= '0;
            ovf_q      <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end else if (conv_mag_d[MW-1]) begin
            // Carry out of the add: renormalise right, LSB truncated.
            sign_out_q <= conv_sign_d;
            exp_out_q  <= exp_inc_d;
            if (exp_inc_d == EXP_MAX) begin
              mant_q <= '0;
              ovf_q  <= 1'b1;
            end else begin
              mant_q <= conv_mag_d[MW-2:1];
            end
            valid_q <= 1'b1;
            state_q <= DONE;
          end else if (conv_mag_d[MW-2]) begin
            sign_out_q <= conv_sign_d;
            exp_out_q  <= ereg_q;
            mant_q     <= conv_mag_d[MW-3:0];
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end else begin
            state_q <= NORM;
          end
        end
        // One left shift per cycle; flush once the exponent cannot drop.
        NORM: begin
          if (ereg_q <= EXP_ONE) begin
            sign_out_q <= sign_q;
            exp_out_q  <= '0;
            mant_q     <= '0;
            unf_q      <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end else begin
            mag_q  <= norm_mag_d;
            ereg_q <= exp_dec_d;
            if (mag_q[MW-3]) begin
              sign_out_q <= sign_q;
              exp_out_q  <= exp_dec_d;
              mant_q     <= norm_mag_d;
              valid_q    <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          if (ready_in) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign sign_out  = sign_out_q;
  assign exp_out   = exp_out_q;
  assign mant_out  = mant_q;
  assign zero_out  = zero_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_twos_to_sign_mag_norm.sv
module tb_twos_to_sign_mag_norm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b1;
  logic [24:0] sum_in = '0;
  logic [7:0]  exp_in = '0;
  logic        ready_out, valid_out, sign_out, zero_out, overflow, underflow;
  logic [7:0]  exp_out;
  logic [22:0] mant_out;

  twos_to_sign_mag_norm #(.MW(25), .EW(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .sum_in(sum_in), .exp_in(exp_in), .valid_out(valid_out),
    .ready_in(ready_in), .sign_out(sign_out), .exp_out(exp_out),
    .mant_out(mant_out), .zero_out(zero_out), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // f = {sign, exp[7:0], mant[22:0], zero, overflow, underflow}
  typedef struct {
    logic [34:0] f;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  bit   hold_rdy = 1'b0;
  bit   rand_bp  = 1'b0;
  bit   vprev    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value -> |value|, locate the leading one, then apply the
  // exponent rules (carry, normal, overflow saturation, underflow flush).
  function automatic exp_t model(input logic [24:0] s, input logic [7:0] e);
    exp_t        r;
    int          v, mag, p, k, ei;
    logic        sg;
    logic [22:0] m;
    v   = int'($signed(s));
    sg  = (v < 0);
    mag = sg ? -v : v;
    ei  = int'(e);
    r.acc = 0;
    if (mag == 0) begin
      r.f = {1'b0, 8'd0, 23'd0, 3'b100};
      r.lat = 2;
    end else if (ei == 255) begin
      r.f = {sg, 8'hff, 23'd0, 3'b010};
      r.lat = 2;
    end else begin
      p = 0;
      for (int i = 0; i < 25; i++) if (mag[i]) p = i;
      if (p == 24) begin
        if (ei + 1 == 255) r.f = {sg, 8'hff, 23'd0, 3'b010};
        else begin
          m = mag[23:1];
          r.f = {sg, 8'(ei + 1), m, 3'b000};
        end
        r.lat = 2;
      end else begin
        k = 23 - p;
        if (k == 0 || ei - k >= 1) begin
          m = 23'(mag << k);
          r.f = {sg, 8'(ei - k), m, 3'b000};
          r.lat = 2 + k;
        end else begin
          r.f = {sg, 8'd0, 23'd0, 3'b001};
          r.lat = 3 + ((ei >= 2) ? ei - 1 : 0);
        end
      end
    end
    return r;
  endfunction

  // Downstream ready: forced low, randomly throttled, or always high.
  always @(posedge clk) begin
    #1;
    if (hold_rdy)     ready_in = 1'b0;
    else if (rand_bp) ready_in = ($urandom_range(0, 3) != 0);
    else              ready_in = 1'b1;
  end

  // Monitor: latency on the rising edge of valid_out, fields on handshake.
  always @(negedge clk) begin
    if (rst) begin
      vprev = 1'b0;
    end else begin
      if (valid_out && !vprev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: valid_out rose with nothing outstanding (cycle %0d)", cyc);
        end else begin
          chk("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
        end
      end
      if (valid_out && ready_in && sb.size() != 0) begin
        chk("fields", 64'({sign_out, exp_out, mant_out, zero_out, overflow, underflow}), 64'(sb[0].f));
        chk("flags_exclusive", 64'($countones({zero_out, overflow, underflow}) <= 1), 64'd1);
        void'(sb.pop_front());
      end
      vprev = valid_out;
    end
  end

  task automatic send(input logic [24:0] s, input logic [7:0] e);
    exp_t x;
    int   n;
    n = 0;
    @(negedge clk);
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: ready_out got 0 expected 1 within 200 cycles");
      return;
    end
    sum_in   = s;
    exp_in   = e;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    x = model(s, e);
    x.acc = cyc;
    sb.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] snap;
    logic [24:0] s;
    logic [7:0]  e;
    int          n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({valid_out, sign_out, exp_out, mant_out, zero_out, overflow, underflow}), 64'd0);
    chk("reset_ready", 64'(ready_out), 64'd1);
    rst = 1'b0;

    // Directed cases
    send(25'h0800000, 8'd127); drain();
    send(25'h1400000, 8'd127); drain();
    send(25'h1000000, 8'd100); drain();
    send(25'h1000000, 8'd254); drain();
    send(25'h0000001, 8'd127); drain();
    send(25'h0000100, 8'd5);   drain();
    send(25'h0123456, 8'd255); drain();
    send(25'h0800000, 8'd0);   drain();
    send(25'h1FFFFFF, 8'd1);   drain();

    // Zero result held under backpressure; a stray valid_in must be ignored
    hold_rdy = 1'b1;
    send(25'h0000000, 8'd90);
    n = 0;
    while (!valid_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(valid_out), 64'd1);
    snap = {sign_out, exp_out, mant_out, zero_out, overflow, underflow};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        sum_in   = 25'h0800000;
        exp_in   = 8'd127;
        valid_in = 1'b1;
      end
      if (i == 5) valid_in = 1'b0;
      chk("bp_stable", 64'({sign_out, exp_out, mant_out, zero_out, overflow, underflow}), 64'(snap));
      chk("bp_valid_held", 64'(valid_out), 64'd1);
      chk("bp_ready_out", 64'(ready_out), 64'd0);
    end
    valid_in = 1'b0;
    hold_rdy = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("bp_no_extra", 64'(valid_out), 64'd0);

    // Reset while normalising discards the operation
    send(25'h0000001, 8'd127);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_valid", 64'(valid_out), 64'd0);
    chk("midreset_ready", 64'(ready_out), 64'd1);
    send(25'h0800000, 8'd127); drain();

    // Randomised traffic with random downstream throttling
    rand_bp = 1'b1;
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 4))
        0: s = 25'($urandom);
        1: s = 25'(1) << $urandom_range(0, 24);
        2: begin
          case ($urandom_range(0, 5))
            0: s = 25'h0000000;
            1: s = 25'h0000001;
            2: s = 25'h1000000;
            3: s = 25'h1FFFFFF;
            4: s = 25'h0FFFFFF;
            default: s = 25'h0800000;
          endcase
        end
        3: s = 25'($urandom_range(0, 255));
        default: s = -(25'($urandom_range(1, 70000)));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: e = 8'd0;
          1: e = 8'd1;
          2: e = 8'd2;
          3: e = 8'd127;
          4: e = 8'd254;
          default: e = 8'd255;
        endcase
      end else begin
        e = 8'($urandom);
      end
      send(s, e);
    end
    drain();
    rand_bp = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
